// File: rtl/brick_hit_controller.sv
// Brick collision scanner: per frame tick, finds the first brick hit by the
// ball, bumps its damage state, writes it to the display, reports bounce/score.
// Ports: CLK_25MH, reset (sync, active-low), frame_tick, ball_x, ball_y in;
//   active_write_enable/position/data to display; bounce_x, bounce_y,
//   scan_done, busy, score, blocks_remaining, level_clear to game logic.
module brick_hit_controller #(
   parameter int BALL_SIZE       = 7,
   parameter int BLOCK_SPACING_X = 40,
   parameter int BLOCK_WIDTH     = 80,
   parameter int BLOCK_HEIGHT    = 30,
   parameter int FIRST_ROW_Y     = 40,
   parameter int SECOND_ROW_Y    = 90,
   parameter int HITS_TO_BREAK   = 3
) (
   input  logic       CLK_25MH,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic [9:0] ball_x,
   input  logic [9:0] ball_y,
   output logic       active_write_enable,
   output logic [5:0] active_position,
   output logic [1:0] active_data,
   output logic       bounce_x,
   output logic       bounce_y,
   output logic       scan_done,
   output logic       busy,
   output logic [9:0] score,
   output logic [3:0] blocks_remaining,
   output logic       level_clear
);

   typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_e;

   localparam logic [10:0] BS_W   = 11'(BALL_SIZE);
   localparam logic [10:0] SPX_W  = 11'(BLOCK_SPACING_X);
   localparam logic [10:0] STEP_W = 11'(BLOCK_SPACING_X + BLOCK_WIDTH);
   localparam logic [10:0] BW_W   = 11'(BLOCK_WIDTH);
   localparam logic [10:0] BH_W   = 11'(BLOCK_HEIGHT);
   localparam logic [10:0] Y1_W   = 11'(FIRST_ROW_Y);
   localparam logic [10:0] Y2_W   = 11'(SECOND_ROW_Y);
   localparam logic [1:0]  HTB    = 2'(HITS_TO_BREAK);

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [9:0]  bx_q, bx_d;
   logic [9:0]  by_q, by_d;
   logic [1:0]  dmg_q [0:9];
   logic [1:0]  dmg_d [0:9];
   logic        we_q, we_d;
   logic [5:0]  pos_q, pos_d;
   logic [1:0]  dat_q, dat_d;
   logic        bncx_q, bncx_d;
   logic        bncy_q, bncy_d;
   logic        done_q, done_d;
   logic [9:0]  score_q, score_d;
   logic [3:0]  blocks_q, blocks_d;

   // Geometry of the brick selected by idx_q (held through WRITE)
   logic [3:0]  col_c;
   logic [10:0] brk_x, brk_y, brk_r, brk_b;
   logic [10:0] ball_l, ball_t, ball_r, ball_b;
   logic [1:0]  cur_dmg, new_dmg;
   logic        hit, straddle, contain;

   always_comb begin
      col_c   = (idx_q >= 4'd5) ? idx_q - 4'd5 : idx_q;
      brk_x   = SPX_W + STEP_W * {7'd0, col_c};
      brk_y   = (idx_q >= 4'd5) ? Y2_W : Y1_W;
      brk_r   = brk_x + BW_W;
      brk_b   = brk_y + BH_W;
      ball_l  = {1'b0, bx_q};
      ball_t  = {1'b0, by_q};
      ball_r  = ball_l + BS_W;
      ball_b  = ball_t + BS_W;
      cur_dmg = dmg_q[idx_q];
      new_dmg = cur_dmg + 2'd1;
      hit     = (cur_dmg != HTB)
              && (ball_l <= brk_r) && (ball_r >= brk_x)
              && (ball_t <= brk_b) && (ball_b >= brk_y);
      straddle = (ball_l < brk_x) || (ball_r > brk_r);
      contain  = (ball_t >= brk_y) && (ball_b <= brk_b);
   end

   // State register and all registered outputs
   always_ff @(posedge CLK_25MH) begin
      if (!reset) begin
         state_q  <= IDLE;
         idx_q    <= 4'd0;
         bx_q     <= 10'd0;
         by_q     <= 10'd0;
         for (int i = 0; i < 10; i++) dmg_q[i] <= 2'd0;
         we_q     <= 1'b0;
         pos_q    <= 6'd0;
         dat_q    <= 2'd0;
         bncx_q   <= 1'b0;
         bncy_q   <= 1'b0;
         done_q   <= 1'b0;
         score_q  <= 10'd0;
         blocks_q <= 4'd10;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         bx_q     <= bx_d;
         by_q     <= by_d;
         for (int i = 0; i < 10; i++) dmg_q[i] <= dmg_d[i];
         we_q     <= we_d;
         pos_q    <= pos_d;
         dat_q    <= dat_d;
         bncx_q   <= bncx_d;
         bncy_q   <= bncy_d;
         done_q   <= done_d;
         score_q  <= score_d;
         blocks_q <= blocks_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      bx_d    = bx_q;
      by_d    = by_q;
      unique case (state_q)
         IDLE: begin
            if (frame_tick) begin
               state_d = SCAN;
               idx_d   = 4'd0;
               bx_d    = ball_x;
               by_d    = ball_y;
            end
         end
         SCAN: begin
            if (hit)                state_d = WRITE;
            else if (idx_q == 4'd9) state_d = DONE;
            else                    idx_d   = idx_q + 4'd1;
         end
         WRITE:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      we_d     = 1'b0;
      pos_d    = pos_q;
      dat_d    = dat_q;
      bncx_d   = 1'b0;
      bncy_d   = 1'b0;
      done_d   = 1'b0;
      score_d  = score_q;
      blocks_d = blocks_q;
      for (int i = 0; i < 10; i++) dmg_d[i] = dmg_q[i];
      unique case (1'b1)
         (state_q == WRITE): begin
            we_d   = 1'b1;
            pos_d  = {2'b00, idx_q};
            dat_d  = new_dmg;
            dmg_d[idx_q] = new_dmg;
            // side hit only if ball pokes past an edge while fully inside
            // the brick's vertical band
            bncx_d = straddle && contain;
            bncy_d = !(straddle && contain);
            score_d = (score_q == 10'd1023) ? score_q : score_q + 10'd1;
            if (new_dmg == HTB && blocks_q != 4'd0)
               blocks_d = blocks_q - 4'd1;
         end
         (state_q == DONE): done_d = 1'b1;
         default: ;
      endcase
   end

   assign active_write_enable = we_q;
   assign active_position     = pos_q;
   assign active_data         = dat_q;
   assign bounce_x            = bncx_q;
   assign bounce_y            = bncy_q;
   assign scan_done           = done_q;
   assign busy                = (state_q != IDLE);
   assign score               = score_q;
   assign blocks_remaining    = blocks_q;
   assign level_clear         = (blocks_q == 4'd0);

endmodule

// File: tb/tb_brick_hit_controller.sv
// Directed bench for brick_hit_controller: hand-computed hit index,
// latency, bounce direction, score and brick counts.
module tb_brick_hit_controller;

   logic       clk;
   logic       reset;
   logic       frame_tick;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic       active_write_enable;
   logic [5:0] active_position;
   logic [1:0] active_data;
   logic       bounce_x;
   logic       bounce_y;
   logic       scan_done;
   logic       busy;
   logic [9:0] score;
   logic [3:0] blocks_remaining;
   logic       level_clear;

   brick_hit_controller dut (
      .CLK_25MH            (clk),
      .reset               (reset),
      .frame_tick          (frame_tick),
      .ball_x              (ball_x),
      .ball_y              (ball_y),
      .active_write_enable (active_write_enable),
      .active_position     (active_position),
      .active_data         (active_data),
      .bounce_x            (bounce_x),
      .bounce_y            (bounce_y),
      .scan_done           (scan_done),
      .busy                (busy),
      .score               (score),
      .blocks_remaining    (blocks_remaining),
      .level_clear         (level_clear)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Results of the last scan, cycle numbers relative to tick edge T
   int         wr_at, dn_at, n_wr, n_dn;
   logic [5:0] w_pos;
   logic [1:0] w_dat;
   logic       w_bx, w_by, busy1;

   task automatic do_reset();
      @(negedge clk);
      reset      = 1'b0;
      frame_tick = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // t2: extra tick sampled at edge T+t2; ra: reset low at edges T+ra, T+ra+1
   task automatic run_scan(input logic [9:0] x, input logic [9:0] y,
                           input int t2, input int ra);
      wr_at = -1; dn_at = -1; n_wr = 0; n_dn = 0;
      w_pos = '0; w_dat = '0; w_bx = 0; w_by = 0; busy1 = 0;
      @(negedge clk);
      ball_x     = x;
      ball_y     = y;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      for (int n = 0; n <= 20; n++) begin
         if (n > 0) begin
            @(negedge clk);
            if (n == 1) busy1 = busy;
            if (active_write_enable) begin
               n_wr++;
               wr_at = n;
               w_pos = active_position;
               w_dat = active_data;
               w_bx  = bounce_x;
               w_by  = bounce_y;
            end
            if (scan_done) begin
               n_dn++;
               dn_at = n;
            end
         end
         frame_tick = (t2 != 0 && n == t2 - 1);
         if (ra != 0 && n == ra - 1) reset = 1'b0;
         if (ra != 0 && n == ra + 1) reset = 1'b1;
      end
      frame_tick = 1'b0;
   endtask

   int sum_wr;

   initial begin
      reset      = 1'b0;
      frame_tick = 1'b0;
      ball_x     = '0;
      ball_y     = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_score",  32'(score), 0);
      chk("rst_blocks", 32'(blocks_remaining), 10);
      chk("rst_clear",  32'(level_clear), 0);
      chk("rst_strobes", 32'({active_write_enable, bounce_x,
                              bounce_y, scan_done}), 0);
      chk("rst_busy",   32'(busy), 0);
      chk("rst_pos",    32'(active_position), 0);

      // top face hit on brick 0
      run_scan(10'd100, 10'd60, 0, 0);
      chk("b0_busy",  32'(busy1), 1);
      chk("b0_wr_at", wr_at, 2);
      chk("b0_pos",   32'(w_pos), 0);
      chk("b0_dat",   32'(w_dat), 1);
      chk("b0_bnc",   32'({w_bx, w_by}), 32'b01);
      chk("b0_score", 32'(score), 1);
      chk("b0_dn_at", dn_at, 3);
      chk("b0_idle",  32'(busy), 0);

      // ball straddles right edge of brick 6
      do_reset();
      run_scan(10'd236, 10'd100, 0, 0);
      chk("b6_wr_at", wr_at, 8);
      chk("b6_pos",   32'(w_pos), 6);
      chk("b6_dat",   32'(w_dat), 1);
      chk("b6_bnc",   32'({w_bx, w_by}), 32'b10);
      chk("b6_dn_at", dn_at, 9);
      chk("b6_hold",  32'({active_position, active_data}), 32'({6'd6, 2'd1}));
      do_reset();
      @(negedge clk);
      chk("rst2_pos", 32'({active_position, active_data}), 0);

      // damage progression on brick 0
      run_scan(10'd100, 10'd60, 0, 0);
      chk("d1_dat", 32'(w_dat), 1);
      run_scan(10'd100, 10'd60, 0, 0);
      chk("d2_dat", 32'(w_dat), 2);
      chk("d2_blk", 32'(blocks_remaining), 10);
      run_scan(10'd100, 10'd60, 0, 0);
      chk("d3_dat", 32'(w_dat), 3);
      chk("d3_blk", 32'(blocks_remaining), 9);
      run_scan(10'd100, 10'd60, 0, 0);
      chk("d4_nwr",   n_wr, 0);
      chk("d4_dn_at", dn_at, 11);
      chk("d4_score", 32'(score), 3);

      // miss, with a second tick while busy
      do_reset();
      run_scan(10'd300, 10'd300, 4, 0);
      chk("miss_nwr",  n_wr, 0);
      chk("miss_ndn",  n_dn, 1);
      chk("miss_dnat", dn_at, 11);
      chk("miss_idle", 32'(busy), 0);

      // reset aborts a scan aimed at brick 5
      run_scan(10'd60, 10'd100, 0, 2);
      chk("abort_nwr",   n_wr, 0);
      chk("abort_score", 32'(score), 0);
      chk("abort_blk",   32'(blocks_remaining), 10);
      chk("abort_idle",  32'(busy), 0);
      run_scan(10'd60, 10'd100, 0, 0);
      chk("b5_wr_at", wr_at, 7);
      chk("b5_pos",   32'(w_pos), 5);
      chk("b5_dat",   32'(w_dat), 1);

      // clear the level
      do_reset();
      sum_wr = 0;
      for (int i = 0; i < 10; i++) begin
         for (int h = 0; h < 3; h++) begin
            run_scan(10'(40 + 120 * (i % 5) + 10),
                     10'((i < 5 ? 40 : 90) + 10), 0, 0);
            sum_wr += n_wr;
         end
         chk($sformatf("clr_pos%0d", i), 32'(w_pos), 32'(i));
         chk($sformatf("clr_dat%0d", i), 32'(w_dat), 3);
      end
      chk("clr_nwr",   sum_wr, 30);
      chk("clr_blk",   32'(blocks_remaining), 0);
      chk("clr_flag",  32'(level_clear), 1);
      chk("clr_score", 32'(score), 30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
